rom_dl_ctrl: RTL and testbench
==============================

# rom_dl_ctrl

Download sequencer and shared-port arbiter between the HPS ROM download stream and the game board's ROM/RAM array. It holds the Williams2 board in reset until a complete image has loaded. It buffers download bytes into the shared memory port with game reads taking priority. It reports the byte count and a sticky error for short, overlong or dropped images. It sits between the hps_io download signals and the williams2 `dn_*`/reset inputs.

## Interface
Parameters:
- ROM_INDEX, 16'd0, value of `dl_index` that selects this image; other indices are ignored.
- EXPECTED_BYTES, 18'h2C000, exact image size; valid addresses are 0..EXPECTED_BYTES-1.
- RELEASE_CYCLES, 16, number of clocks `cpu_reset` stays high after the last byte commits (1..255).

Ports:
- clock_12  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  download in progress.
- dl_wr  in  1  one-cycle byte strobe.
- dl_addr  in  18  byte address.
- dl_data  in  8  byte value.
- dl_index  in  16  image index.
- dl_wait  out  1  upstream must hold the next strobe while this is high.
- game_rd  in  1  game read request; has priority on the port.
- game_addr  in  18  game read address.
- mem_addr  out  18  shared port address.
- mem_data  out  8  shared port write data.
- mem_we  out  1  shared port write enable.
- cpu_reset  out  1  hold the game board in reset.
- load_done  out  1  a complete image has been released.
- load_err  out  1  sticky error flag.
- byte_count  out  18  number of accepted bytes in the current load.

## Operation
FSM states: WAIT_DL, LOAD, DRAIN, HOLD, RUN.
- Reset:
  - State goes to WAIT_DL.
  - `cpu_reset`=1; `load_done`=0; `load_err`=0; `byte_count`=0.
  - Write buffer empty; `mem_we`=0; `dl_wait`=0.
- WAIT_DL or RUN, with `dl_active`=1 and `dl_index`==ROM_INDEX:
  - State goes to LOAD.
  - `cpu_reset`=1 and `load_done`=0 from the next cycle.
  - `byte_count` and `load_err` are cleared.
- LOAD, `dl_wr` with a matching index:
  - If `dl_addr` < EXPECTED_BYTES, the byte is captured into the 1-entry buffer and `byte_count` increments, saturating at 18'h3FFFF.
  - Otherwise the byte is dropped and `load_err` is set.
- Buffer commit: `mem_we` = buffer valid && !`game_rd`. A commit and a new capture may happen in the same cycle.
- Protocol violation: `dl_wr` arrives while the buffer is valid and `game_rd`=1. The byte is dropped and `load_err` is set.
- `dl_active` falls:
  - LOAD goes to DRAIN.
  - DRAIN waits until the buffer is empty, then goes to HOLD and loads the release counter with RELEASE_CYCLES.
- HOLD:
  - The counter decrements each cycle.
  - At 0 the state goes to RUN, `cpu_reset`=0 and `load_done`=1.
  - `load_err` is additionally set if `byte_count` != EXPECTED_BYTES. It is still released; the error is only reported.
- Port mux:
  - `mem_addr` = `game_addr` when `game_rd`=1, else the buffered address.
  - `mem_data` = buffered data.
- A non-matching `dl_active` or `dl_wr` has no effect in any state.

## Timing
- Capture: `dl_wr` at cycle n puts the byte in the buffer at n+1. `mem_we`=1 at n+1 if `game_rd`=0.
- `mem_we`, `mem_addr` and `dl_wait` are combinational from the registered buffer and `game_rd`. `dl_wait` = buffer valid && `game_rd`.
- Release latency: the last commit at cycle c gives `cpu_reset` falling at c+1+RELEASE_CYCLES.
- Re-download while in RUN: `cpu_reset` rises 1 cycle after the rising edge of `dl_active`.
- `reset` asserted mid-load: the buffer is discarded and all outputs return to their reset values the next cycle.
- `dl_active` falling in the same cycle as a final `dl_wr`: the byte is captured, then drained in DRAIN.

## Structure
- Shared package `williams2_pkg`: the FSM state enum and a `DL_ADDR_W`=18 constant.
- Sub-module `dl_wbuf`: 1-entry write buffer with a valid flag. It takes capture and commit strobes, handles simultaneous capture and commit, and holds the address/data registers.
- The FSM, counters and port mux stay in `rom_dl_ctrl`.

## Test plan
- Clean load: EXPECTED_BYTES=16, RELEASE_CYCLES=4, 16 strobes with `game_rd`=0 -> 16 writes at addresses 0..15 with matching data; `byte_count`=16; `cpu_reset` falls 5 cycles after the last commit; `load_done`=1, `load_err`=0.
- Contention: buffer valid with `game_rd` held for 3 cycles -> `dl_wait`=1 for 3 cycles, `mem_addr`=`game_addr`, no write; the commit happens on the first cycle `game_rd`=0.
- Overlong or dropped bytes: a write to `dl_addr`=16 (with EXPECTED_BYTES=16), or a strobe while `dl_wait`=1 -> no write, `load_err`=1, and the count is unchanged.
- Short image: 10 bytes, then `dl_active` falls -> release still occurs, `load_err`=1, `byte_count`=10.
- Index filter and re-load: `dl_index`=1 during RUN -> no change. Then index 0 -> `cpu_reset`=1 next cycle and counters cleared; reassert `reset` mid-load -> outputs return to their reset values next cycle.

Source files
------------

// File: rtl/williams2_pkg.sv
// Shared types and constants for the Williams2 ROM download path.
package williams2_pkg;

  localparam int unsigned DL_ADDR_W = 18;

  typedef enum logic [2:0] {
    WAIT_DL,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } dl_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DL_ADDR_W-1:0] sat_inc(input logic [DL_ADDR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dl_wbuf.sv
// One-entry write buffer between the download stream and the shared memory port.
module dl_wbuf #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              capture_i,
  input  logic              commit_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Capture wins over commit so a same-cycle commit and refill leaves the entry full.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (commit_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers; reset discards any pending byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: holds the game board in reset while an image loads,
// feeds download bytes into the shared memory port behind game reads, and
// reports the byte count plus a sticky error for bad images.
module rom_dl_ctrl
  import williams2_pkg::*;
#(
  parameter logic [15:0]          ROM_INDEX      = 16'd0,
  parameter logic [DL_ADDR_W-1:0] EXPECTED_BYTES = 18'h2C000,
  parameter int unsigned          RELEASE_CYCLES = 16
) (
  input  logic                 clock_12,
  input  logic                 reset,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [7:0]           dl_data,
  input  logic [15:0]          dl_index,
  output logic                 dl_wait,
  input  logic                 game_rd,
  input  logic [DL_ADDR_W-1:0] game_addr,
  output logic [DL_ADDR_W-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_we,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_err,
  output logic [DL_ADDR_W-1:0] byte_count
);

  localparam logic [7:0] REL_INIT = 8'(RELEASE_CYCLES);

  dl_state_e            state_q, state_d;
  logic [7:0]           rel_cnt_q, rel_cnt_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;
  logic [DL_ADDR_W-1:0] byte_count_q, byte_count_d;

  logic                 buf_valid;
  logic [DL_ADDR_W-1:0] buf_addr;
  logic [7:0]           buf_data;

  logic idx_match;
  logic commit;
  logic blocked;
  logic strobe;
  logic in_range;
  logic capture;

  assign idx_match = (dl_index == ROM_INDEX);
  assign commit    = buf_valid && !game_rd;
  assign blocked   = buf_valid && game_rd;
  assign strobe    = dl_wr && idx_match && (state_q == LOAD);
  assign in_range  = (dl_addr < EXPECTED_BYTES);
  assign capture   = strobe && in_range && !blocked;

  dl_wbuf #(
    .ADDR_W(DL_ADDR_W),
    .DATA_W(8)
  ) u_wbuf (
    .clk_i    (clock_12),
    .rst_i    (reset),
    .capture_i(capture),
    .commit_i (commit),
    .addr_i   (dl_addr),
    .data_i   (dl_data),
    .valid_o  (buf_valid),
    .addr_o   (buf_addr),
    .data_o   (buf_data)
  );

  // Next-state, counters and status flags.
  always_comb begin
    state_d      = state_q;
    rel_cnt_d    = rel_cnt_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    byte_count_d = byte_count_q;
    unique case (state_q)
      WAIT_DL, RUN: begin
        if (dl_active && idx_match) begin
          state_d      = LOAD;
          cpu_reset_d  = 1'b1;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
          byte_count_d = '0;
        end
      end
      LOAD: begin
        if (strobe) begin
          if (capture) byte_count_d = sat_inc(byte_count_q);
          else         load_err_d   = 1'b1;
        end
        if (!dl_active) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the buffer is empty after this edge, so the release
        // delay counts from the final commit rather than one cycle later.
        if (!buf_valid || commit) begin
          state_d   = HOLD;
          rel_cnt_d = REL_INIT;
        end
      end
      HOLD: begin
        rel_cnt_d = rel_cnt_q - 8'd1;
        if (rel_cnt_q <= 8'd1) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
          load_done_d = 1'b1;
          if (byte_count_q != EXPECTED_BYTES) load_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_DL;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      state_q      <= WAIT_DL;
      rel_cnt_q    <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rel_cnt_q    <= rel_cnt_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign mem_we     = commit;
  assign dl_wait    = blocked;
  assign mem_addr   = game_rd ? game_addr : buf_addr;
  assign mem_data   = buf_data;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl with a 16-byte image and a 4-cycle release.
module tb_rom_dl_ctrl;

  logic        clock_12 = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic [15:0] dl_index;
  logic        dl_wait;
  logic        game_rd;
  logic [17:0] game_addr;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [17:0] byte_count;

  int total = 0;
  int bad   = 0;

  always #5 clock_12 = ~clock_12;

  rom_dl_ctrl #(
    .ROM_INDEX     (16'd0),
    .EXPECTED_BYTES(18'd16),
    .RELEASE_CYCLES(4)
  ) dut (
    .clock_12  (clock_12),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_index  (dl_index),
    .dl_wait   (dl_wait),
    .game_rd   (game_rd),
    .game_addr (game_addr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err),
    .byte_count(byte_count)
  );

  typedef struct {
    logic        rst, act, wr;
    logic [17:0] addr;
    logic [7:0]  data;
    logic        gr;
    logic [17:0] gaddr;
    logic        e_we, e_wait;
    logic [17:0] e_maddr;
    logic [7:0]  e_mdata;
    logic        e_cpurst, e_done, e_err;
    logic [17:0] e_cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(
    input logic rst, act, wr, input logic [17:0] addr, input logic [7:0] data,
    input logic gr, input logic [17:0] gaddr,
    input logic e_we, e_wait, input logic [17:0] e_maddr, input logic [7:0] e_mdata,
    input logic e_cpurst, e_done, e_err, input logic [17:0] e_cnt);
    vec_t v;
    v.rst = rst; v.act = act; v.wr = wr; v.addr = addr; v.data = data;
    v.gr = gr; v.gaddr = gaddr; v.e_we = e_we; v.e_wait = e_wait;
    v.e_maddr = e_maddr; v.e_mdata = e_mdata; v.e_cpurst = e_cpurst;
    v.e_done = e_done; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic act, input logic wr, input logic [17:0] addr,
                       input logic [7:0] data, input logic gr, input logic [17:0] gaddr);
    dl_active = act; dl_wr = wr; dl_addr = addr; dl_data = data;
    game_rd = gr; game_addr = gaddr;
  endtask

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  // Idle with everything low and report the first cycle cpu_reset is seen low.
  task automatic wait_release(output int k_fall);
    k_fall = 0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_12);
      if (!cpu_reset && k_fall == 0) k_fall = k;
      tick();
    end
  endtask

  initial begin
    int k_fall;

    tbl[0]  = mk(0,1,0,18'd0, 8'h00,0,18'd0,   0,0,18'd15, 8'h00,0,1,0,18'd16);
    tbl[1]  = mk(0,1,1,18'd0, 8'h11,0,18'd0,   0,0,18'd15, 8'h00,1,0,0,18'd0);
    tbl[2]  = mk(0,1,0,18'd0, 8'h00,1,18'd100, 0,1,18'd100,8'h00,1,0,0,18'd1);
    tbl[3]  = mk(0,1,0,18'd0, 8'h00,1,18'd101, 0,1,18'd101,8'h00,1,0,0,18'd1);
    tbl[4]  = mk(0,1,0,18'd0, 8'h00,1,18'd102, 0,1,18'd102,8'h00,1,0,0,18'd1);
    tbl[5]  = mk(0,1,0,18'd0, 8'h00,0,18'd0,   1,0,18'd0,  8'h11,1,0,0,18'd1);
    tbl[6]  = mk(0,1,1,18'd1, 8'h33,0,18'd0,   0,0,18'd0,  8'h00,1,0,0,18'd1);
    tbl[7]  = mk(0,1,0,18'd0, 8'h00,1,18'd200, 0,1,18'd200,8'h00,1,0,0,18'd2);
    tbl[8]  = mk(0,1,1,18'd2, 8'h44,1,18'd201, 0,1,18'd201,8'h00,1,0,0,18'd2);
    tbl[9]  = mk(0,1,0,18'd0, 8'h00,0,18'd0,   1,0,18'd1,  8'h33,1,0,1,18'd2);
    tbl[10] = mk(0,1,1,18'd16,8'h55,0,18'd0,   0,0,18'd1,  8'h00,1,0,1,18'd2);
    tbl[11] = mk(0,1,1,18'd3, 8'h66,0,18'd0,   0,0,18'd1,  8'h00,1,0,1,18'd2);
    tbl[12] = mk(1,1,0,18'd0, 8'h00,1,18'd300, 0,1,18'd300,8'h00,1,0,1,18'd3);
    tbl[13] = mk(0,0,0,18'd0, 8'h00,0,18'd0,   0,0,18'd0,  8'h00,1,0,0,18'd0);
    tbl[14] = mk(0,0,0,18'd0, 8'h00,1,18'd5,   0,0,18'd5,  8'h00,1,0,0,18'd0);

    reset = 1'b1; dl_index = 16'd0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick(); tick();
    @(negedge clock_12);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wait", dl_wait, 0);
    tick();
    reset = 1'b0;

    // Clean 16-byte load, dl_active falling with the last strobe.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(i != 15, 1'b1, 18'(i), 8'(8'hA0 + i), 1'b0, '0);
      @(negedge clock_12);
      chk("clean_we", mem_we, (i > 0));
      if (i > 0) begin
        chk("clean_addr", mem_addr, 32'(i - 1));
        chk("clean_data", mem_data, 32'(8'hA0 + i - 1));
      end
      chk("clean_count", byte_count, 32'(i));
      chk("clean_cpu_reset", cpu_reset, 1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clock_12);
    chk("last_we", mem_we, 1);
    chk("last_addr", mem_addr, 15);
    chk("last_data", mem_data, 8'hAF);
    chk("last_count", byte_count, 16);
    tick();
    wait_release(k_fall);
    chk("release_latency", k_fall, 5);
    chk("clean_done", load_done, 1);
    chk("clean_err", load_err, 0);
    chk("clean_count_final", byte_count, 16);

    // Foreign index during RUN is ignored.
    dl_index = 16'd1;
    drive(1'b1, 1'b1, 18'd3, 8'h99, 1'b0, '0);
    tick(); tick();
    @(negedge clock_12);
    chk("idx_cpu_reset", cpu_reset, 0);
    chk("idx_done", load_done, 1);
    chk("idx_count", byte_count, 16);
    chk("idx_we", mem_we, 0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    dl_index = 16'd0;

    // Re-load, contention, dropped strobes, then reset mid-load.
    for (int r = 0; r < 15; r++) begin
      reset = tbl[r].rst;
      drive(tbl[r].act, tbl[r].wr, tbl[r].addr, tbl[r].data, tbl[r].gr, tbl[r].gaddr);
      @(negedge clock_12);
      chk($sformatf("v%0d_we", r), mem_we, tbl[r].e_we);
      chk($sformatf("v%0d_wait", r), dl_wait, tbl[r].e_wait);
      chk($sformatf("v%0d_maddr", r), mem_addr, tbl[r].e_maddr);
      if (tbl[r].e_we) chk($sformatf("v%0d_mdata", r), mem_data, tbl[r].e_mdata);
      chk($sformatf("v%0d_cpurst", r), cpu_reset, tbl[r].e_cpurst);
      chk($sformatf("v%0d_done", r), load_done, tbl[r].e_done);
      chk($sformatf("v%0d_err", r), load_err, tbl[r].e_err);
      chk($sformatf("v%0d_cnt", r), byte_count, tbl[r].e_cnt);
      tick();
    end
    reset = 1'b0;

    // Overlong first byte from a clean error flag.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b1, 18'd16, 8'h77, 1'b0, '0);
    @(negedge clock_12);
    chk("ovl_err_before", load_err, 0);
    tick();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clock_12);
    chk("ovl_we", mem_we, 0);
    chk("ovl_err", load_err, 1);
    chk("ovl_count", byte_count, 0);
    tick();
    wait_release(k_fall);
    chk("ovl_released", (k_fall != 0), 1);

    // Short image re-loaded from RUN: error cleared, then set again at release.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clock_12);
    chk("short_pre_cpu_reset", cpu_reset, 0);
    chk("short_pre_err", load_err, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(i != 9, 1'b1, 18'(i), 8'(i), 1'b0, '0);
      @(negedge clock_12);
      if (i == 0) begin
        chk("short_start_cpu_reset", cpu_reset, 1);
        chk("short_start_err", load_err, 0);
        chk("short_start_count", byte_count, 0);
      end
      tick();
    end
    wait_release(k_fall);
    chk("short_released", (k_fall != 0), 1);
    chk("short_done", load_done, 1);
    chk("short_err", load_err, 1);
    chk("short_count", byte_count, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
